// File: rtl/arith_pkg.sv
// Shared arithmetic definitions for the adder blocks: result modes and
// the width rule that keeps a multi-operand sum from overflowing.
package arith_pkg;

  localparam int SUM_TRUNC = 0;
  localparam int SUM_FULL  = 1;

  // Full-precision width of a sum of num_ops unsigned width-bit operands,
  // or just width when the result is truncated.
  function automatic int sum_width(input int width, input int num_ops, input int sum_mode);
    return (sum_mode == SUM_FULL) ? width + $clog2(num_ops) : width;
  endfunction

endpackage

// File: rtl/acc_out_reg.sv
// Single-entry result register with valid/ready drain. A load in the same
// cycle as a drain replaces the consumed result without a bubble.
module acc_out_reg #(
  parameter int SUM_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [SUM_W-1:0] load_sum,
  input  logic             load_ovf,
  input  logic             out_ready,
  output logic             out_valid,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf
);

  logic             valid_q, valid_d;
  logic [SUM_W-1:0] sum_q, sum_d;
  logic             ovf_q, ovf_d;

  always_comb begin
    valid_d = valid_q;
    sum_d   = sum_q;
    ovf_d   = ovf_q;
    if (valid_q && out_ready) begin
      valid_d = 1'b0;
    end
    if (load) begin
      valid_d = 1'b1;
      sum_d   = load_sum;
      ovf_d   = load_ovf;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= 1'b0;
      sum_q   <= '0;
      ovf_q   <= 1'b0;
    end else begin
      valid_q <= valid_d;
      sum_q   <= sum_d;
      ovf_q   <= ovf_d;
    end
  end

  assign out_valid = valid_q;
  assign out_sum   = sum_q;
  assign out_ovf   = ovf_q;

endmodule

// File: rtl/multi_operand_accumulator.sv
// Streaming multi-operand adder: sums each group of NUM_OPS operands and
// presents the group result (truncated or full precision) with overflow flag.
module multi_operand_accumulator
  import arith_pkg::*;
#(
  parameter int WIDTH    = 5,
  parameter int NUM_OPS  = 11,
  parameter int SUM_MODE = SUM_TRUNC,
  localparam int SUM_W   = sum_width(WIDTH, NUM_OPS, SUM_MODE)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clear,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [SUM_W-1:0] out_sum,
  output logic             out_ovf
);

  localparam int ACC_W = sum_width(WIDTH, NUM_OPS, SUM_FULL);
  localparam int CNT_W = $clog2(NUM_OPS);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [ACC_W-1:0] total;
  logic             is_last;
  logic             accept;
  logic             load;
  logic [SUM_W-1:0] load_sum;
  logic             load_ovf;

  // Handshakes: a transfer happens on a rising edge where valid and ready
  // are both high; valid, once raised, holds its data until that transfer.
  // Only the last operand of a group waits on a pending, unconsumed result.
  always_comb begin
    is_last  = (cnt_q == LAST_CNT);
    in_ready = !rst && !clear && !(is_last && out_valid && !out_ready);
    accept   = in_valid && in_ready;
    total    = acc_q + ACC_W'(in_data);
    load     = accept && is_last;
    load_sum = total[SUM_W-1:0];
    load_ovf = |total[ACC_W-1:WIDTH];

    cnt_d = cnt_q;
    acc_d = acc_q;
    if (clear) begin
      cnt_d = '0;
    end else if (accept) begin
      if (is_last) begin
        cnt_d = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
        acc_d = (cnt_q == '0) ? ACC_W'(in_data) : total;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
      acc_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      acc_q <= acc_d;
    end
  end

  acc_out_reg #(
    .SUM_W (SUM_W)
  ) u_out_reg (
    .clk       (clk),
    .rst       (rst),
    .load      (load),
    .load_sum  (load_sum),
    .load_ovf  (load_ovf),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_sum   (out_sum),
    .out_ovf   (out_ovf)
  );

endmodule

// File: tb/tb_multi_operand_accumulator.sv
// Directed bench: a truncating and a full-precision instance share one
// stimulus stream; results are checked against hand-computed sums.
module tb_multi_operand_accumulator;

  logic       clk;
  logic       rst;
  logic       clear;
  logic       in_valid;
  logic [4:0] in_data;
  logic       out_ready;

  logic       in_ready0, in_ready1;
  logic       out_valid0, out_valid1;
  logic [4:0] out_sum0;
  logic [8:0] out_sum1;
  logic       out_ovf0, out_ovf1;

  int checks;
  int errors;
  int stall_cycles;

  multi_operand_accumulator #(
    .WIDTH    (5),
    .NUM_OPS  (11),
    .SUM_MODE (0)
  ) dut0 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready0),
    .in_data   (in_data),
    .out_valid (out_valid0),
    .out_ready (out_ready),
    .out_sum   (out_sum0),
    .out_ovf   (out_ovf0)
  );

  multi_operand_accumulator #(
    .WIDTH    (5),
    .NUM_OPS  (11),
    .SUM_MODE (1)
  ) dut1 (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .in_valid  (in_valid),
    .in_ready  (in_ready1),
    .in_data   (in_data),
    .out_valid (out_valid1),
    .out_ready (out_ready),
    .out_sum   (out_sum1),
    .out_ovf   (out_ovf1)
  );

  // clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d required=%0d", tag, obs, exp);
    end
  endtask

  task automatic cycle();
    @(posedge clk);
    #1;
  endtask

  // Present one operand and hold it until accepted (bounded wait).
  task automatic send(input logic [4:0] d);
    int n;
    n = 0;
    in_valid = 1'b1;
    in_data  = d;
    #1;
    while (!in_ready0 && n < 20) begin
      @(posedge clk);
      #1;
      n++;
      stall_cycles++;
    end
    checks++;
    assert (n < 20) else begin
      errors++;
      $error("FAIL send_timeout observed=%0d required=<20", n);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    checks       = 0;
    errors       = 0;
    stall_cycles = 0;
    rst       = 1'b1;
    clear     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b1;

    // reset state
    repeat (3) @(posedge clk);
    #1;
    check("rst_in_ready", 32'(in_ready0), 32'd0);
    check("rst_out_valid", 32'(out_valid0), 32'd0);
    check("rst_out_sum", 32'(out_sum0), 32'd0);
    check("rst_out_ovf", 32'(out_ovf0), 32'd0);
    check("rst_out_valid_full", 32'(out_valid1), 32'd0);
    rst = 1'b0;
    #1;
    check("post_rst_in_ready", 32'(in_ready0), 32'd1);

    // eleven 31s: 341 -> 21 truncated
    for (int i = 0; i < 10; i++) send(5'd31);
    check("max_before_last_valid", 32'(out_valid0), 32'd0);
    send(5'd31);
    check("max_valid", 32'(out_valid0), 32'd1);
    check("max_sum", 32'(out_sum0), 32'd21);
    check("max_ovf", 32'(out_ovf0), 32'd1);
    check("max_sum_full", 32'(out_sum1), 32'd341);
    check("max_ovf_full", 32'(out_ovf1), 32'd1);

    // operands 1..11: 66 full, 2 truncated
    send(5'd1);
    check("ramp_drain_valid", 32'(out_valid0), 32'd0);
    for (int i = 2; i <= 11; i++) send(5'(i));
    check("ramp_sum", 32'(out_sum0), 32'd2);
    check("ramp_ovf", 32'(out_ovf0), 32'd1);
    check("ramp_sum_full", 32'(out_sum1), 32'd66);
    check("ramp_ovf_full", 32'(out_ovf1), 32'd1);
    check("ramp_ready_match", 32'(in_ready1), 32'(in_ready0));

    // eleven zeros then eleven ones, back to back
    for (int i = 0; i < 11; i++) send(5'd0);
    check("zeros_valid", 32'(out_valid0), 32'd1);
    check("zeros_sum", 32'(out_sum0), 32'd0);
    check("zeros_ovf", 32'(out_ovf0), 32'd0);
    for (int i = 0; i < 11; i++) send(5'd1);
    check("ones_valid", 32'(out_valid0), 32'd1);
    check("ones_sum", 32'(out_sum0), 32'd11);
    check("ones_ovf", 32'(out_ovf0), 32'd0);
    check("ones_sum_full", 32'(out_sum1), 32'd11);

    // backpressure: result 11 pending, stream next group of 10x5 + 7
    out_ready    = 1'b0;
    stall_cycles = 0;
    for (int i = 0; i < 10; i++) send(5'd5);
    check("bp_no_early_stall", 32'(stall_cycles), 32'd0);
    in_valid = 1'b1;
    in_data  = 5'd7;
    #1;
    check("bp_last_stalled", 32'(in_ready0), 32'd0);
    check("bp_held_valid", 32'(out_valid0), 32'd1);
    check("bp_held_sum", 32'(out_sum0), 32'd11);
    cycle();
    cycle();
    check("bp_still_stalled", 32'(in_ready0), 32'd0);
    check("bp_still_held", 32'(out_sum0), 32'd11);
    out_ready = 1'b1;
    #1;
    check("bp_ready_released", 32'(in_ready0), 32'd1);
    cycle();
    in_valid  = 1'b0;
    out_ready = 1'b0;
    check("bp_swap_valid", 32'(out_valid0), 32'd1);
    check("bp_swap_sum", 32'(out_sum0), 32'd25);
    check("bp_swap_ovf", 32'(out_ovf0), 32'd1);
    check("bp_swap_sum_full", 32'(out_sum1), 32'd57);
    cycle();
    check("bp_new_held", 32'(out_sum0), 32'd25);
    out_ready = 1'b1;
    cycle();
    check("bp_drained", 32'(out_valid0), 32'd0);

    // clear after 5 operands, then clear colliding with the last operand
    for (int i = 0; i < 5; i++) send(5'd9);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd9;
    #1;
    check("clear_in_ready", 32'(in_ready0), 32'd0);
    cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    for (int i = 0; i < 10; i++) send(5'd1);
    clear    = 1'b1;
    in_valid = 1'b1;
    in_data  = 5'd1;
    cycle();
    clear    = 1'b0;
    in_valid = 1'b0;
    check("clear_last_no_result", 32'(out_valid0), 32'd0);
    for (int i = 0; i < 11; i++) send(5'd2);
    check("clear_twos_valid", 32'(out_valid0), 32'd1);
    check("clear_twos_sum", 32'(out_sum0), 32'd22);
    check("clear_twos_ovf", 32'(out_ovf0), 32'd0);
    check("clear_twos_sum_full", 32'(out_sum1), 32'd22);

    // reset mid-group with a result pending
    out_ready = 1'b0;
    for (int i = 0; i < 7; i++) send(5'd4);
    check("pre_rst_pending", 32'(out_valid0), 32'd1);
    rst = 1'b1;
    #1;
    check("mid_rst_in_ready", 32'(in_ready0), 32'd0);
    cycle();
    check("mid_rst_valid", 32'(out_valid0), 32'd0);
    check("mid_rst_sum", 32'(out_sum0), 32'd0);
    rst       = 1'b0;
    out_ready = 1'b1;
    for (int i = 0; i < 11; i++) send(5'd3);
    check("post_rst_valid", 32'(out_valid0), 32'd1);
    check("post_rst_sum", 32'(out_sum0), 32'd1);
    check("post_rst_ovf", 32'(out_ovf0), 32'd1);
    check("post_rst_sum_full", 32'(out_sum1), 32'd33);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
